clock_div_controller: RTL and testbench

- Run-time controller for the team's toggle-style clock divider.
- Owns the divide counter and sequences start/stop of the divided clock.
- Loads new half-period values through a valid/ready handshake; new values take effect only on full-period boundaries, so the output never glitches.
- Sits between the board clock (100 MHz) and the slow-clock consumers (FSM steppers, display scan); replaces fixed-ratio dividers where the rate must change in the field.

---
 rtl/clock_div_controller.sv | 119 +++++++++++
 tb/tb_clock_div_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_controller.sv
// Run-time toggle clock divider with a glitch-free half-period
// reload through a valid/ready config handshake.
module clock_div_controller #(
  parameter int unsigned      CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = 4999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] phalf_q, phalf_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             rdy_q, rdy_d;
  logic             term;
  logic             apply;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cntr_q  <= '0;
      act_q   <= DEFAULT_HALF;
      phalf_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      act_q   <= act_d;
      phalf_q <= phalf_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    act_d   = act_q;
    phalf_d = phalf_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    pend_d  = pend_q;
    rdy_d   = rdy_q;
    apply   = 1'b0;
    term    = (cntr_q == act_q);
    unique case (state_q)
      IDLE: begin
        cntr_d = '0;
        clk_d  = 1'b0;
        apply  = pend_q;
        if (en) state_d = RUN;
      end
      RUN: begin
        cntr_d = term ? '0 : cntr_q + 1'b1;
        if (!en && !clk_q) begin
          // low phase may be cut short; output is already low
          state_d = IDLE;
          cntr_d  = '0;
        end else begin
          if (term) begin
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
            apply  = pend_q & clk_q;
          end
          if (!en) state_d = term ? IDLE : STOP;
        end
      end
      STOP: begin
        cntr_d = term ? '0 : cntr_q + 1'b1;
        if (term) begin
          clk_d   = 1'b0;
          state_d = IDLE;
          apply   = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // apply needs a pending config, so it never races a transfer
    if (apply) begin
      act_d  = phalf_q;
      pend_d = 1'b0;
      rdy_d  = 1'b1;
    end else if (cfg_valid && rdy_q) begin
      phalf_d = cfg_half;
      pend_d  = 1'b1;
      rdy_d   = 1'b0;
    end
  end

  assign cfg_ready = rdy_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign running   = (state_q != IDLE);
  assign cur_half  = act_q;

endmodule

// File: tb/tb_clock_div_controller.sv
// Bench for clock_div_controller: period-position reference model
// driven by directed and $urandom stimulus.
module tb_clock_div_controller;

  localparam int W = 32;
  localparam logic [W+3:0] RST_V = {4'b0001, 32'd4999};

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_half;
  logic         cfg_ready;
  logic         clk_out;
  logic         tick;
  logic         running;
  logic [W-1:0] cur_half;
  logic [W+3:0] obs;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc_n  = 0;

  bit     m_run, m_stop, m_pend, m_rdy;
  longint m_pos, m_half, m_phalf;

  always #5 clk = ~clk;

  clock_div_controller dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .clk_out  (clk_out),
    .tick     (tick),
    .running  (running),
    .cur_half (cur_half)
  );

  assign obs = {clk_out, tick, running, cfg_ready, cur_half};

  task automatic m_reset();
    m_run   = 0;
    m_stop  = 0;
    m_pend  = 0;
    m_rdy   = 1;
    m_pos   = 0;
    m_half  = 4999;
    m_phalf = 0;
  endtask

  function automatic bit m_clk();
    return m_run && (m_pos >= m_half + 1);
  endfunction

  // pos counts edges since run entry or the last falling edge
  task automatic m_step(input bit e, input bit v,
                        input logic [W-1:0] h);
    bit ap;
    ap = 0;
    if (!m_run) begin
      ap = m_pend;
      if (e) begin
        m_run  = 1;
        m_pos  = 0;
        m_stop = 0;
      end
    end else if (!m_stop && !e && !m_clk()) begin
      m_run = 0;
    end else begin
      if (!e) m_stop = 1;
      m_pos++;
      if (m_pos == 2 * (m_half + 1)) begin
        m_pos = 0;
        ap    = m_pend;
        if (m_stop) m_run = 0;
      end
    end
    if (ap) begin
      m_half = m_phalf;
      m_pend = 0;
      m_rdy  = 1;
    end else if (v && m_rdy) begin
      m_phalf = longint'(h);
      m_pend  = 1;
      m_rdy   = 0;
    end
  endtask

  function automatic logic [W+3:0] exp_v();
    logic c, t;
    logic [W-1:0] hh;
    c  = m_clk();
    t  = m_run && (m_pos == m_half + 1);
    hh = m_half[W-1:0];
    return {c, t, m_run, m_rdy, hh};
  endfunction

  task automatic cyc(input bit e, input bit v,
                     input logic [W-1:0] h);
    en        = e;
    cfg_valid = v;
    cfg_half  = h;
    @(posedge clk);
    m_step(e, v, h);
    cyc_n++;
    #1;
  endtask

  task automatic go_idle();
    int i;
    for (i = 0; i < 12000 && m_run; i++) cyc(0, 0, '0);
    if (m_run) begin
      n_chk++;
      n_fail++;
      $display("FAIL go_idle timeout running=%0b", running);
    end
  endtask

  task automatic set_half(input logic [W-1:0] h);
    go_idle();
    cyc(0, 1, h);
    cyc(0, 0, '0);
  endtask

  task automatic test_reset();
    rst = 1;
    en = 0;
    cfg_valid = 0;
    cfg_half = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n_chk++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL reset got=%h exp=%h", obs, RST_V);
    end
  endtask

  task automatic test_default();
    longint tk[$];
    longint e0;
    e0 = cyc_n + 1;
    for (int i = 0; i < 20100; i++) begin
      cyc(1, 0, '0);
      if (tick) tk.push_back(cyc_n);
      n_chk++;
      if (obs !== exp_v()) begin
        n_fail++;
        $display("FAIL default cyc=%0d got=%h exp=%h",
                 cyc_n, obs, exp_v());
      end
    end
    n_chk++;
    if (tk.size() != 2 || tk[0] != e0 + 5000 ||
        tk[1] != e0 + 15000) begin
      n_fail++;
      $display("FAIL default_ticks n=%0d first=%0d exp=%0d",
               tk.size(), tk.size() ? tk[0] : -1, e0 + 5000);
    end
  endtask

  task automatic test_cfg_idle();
    longint tk[$];
    longint k;
    go_idle();
    cyc(0, 1, 2);
    n_chk++;
    if (cfg_ready !== 1'b0 || cur_half !== 32'd4999) begin
      n_fail++;
      $display("FAIL cfg_xfer rdy=%b half=%0d exp 0/4999",
               cfg_ready, cur_half);
    end
    cyc(0, 0, '0);
    n_chk++;
    if (cfg_ready !== 1'b1 || cur_half !== 32'd2) begin
      n_fail++;
      $display("FAIL cfg_apply rdy=%b half=%0d exp 1/2",
               cfg_ready, cur_half);
    end
    k = cyc_n + 1;
    for (int i = 0; i < 18; i++) begin
      cyc(1, 0, '0);
      if (tick) tk.push_back(cyc_n);
      n_chk++;
      if (obs !== exp_v()) begin
        n_fail++;
        $display("FAIL half2 cyc=%0d got=%h exp=%h",
                 cyc_n, obs, exp_v());
      end
    end
    n_chk++;
    if (tk.size() != 3 || tk[0] != k + 3 ||
        tk[1] != k + 9 || tk[2] != k + 15) begin
      n_fail++;
      $display("FAIL half2_ticks n=%0d first=%0d exp=%0d",
               tk.size(), tk.size() ? tk[0] : -1, k + 3);
    end
  endtask

  task automatic test_cfg_run();
    logic prev;
    for (int i = 0; i < 10 && m_pos != 4; i++) cyc(1, 0, '0);
    cyc(1, 1, 0);
    for (int i = 0; i < 10 && !m_rdy; i++) begin
      cyc(1, 1, 5);
      n_chk++;
      if (obs !== exp_v()) begin
        n_fail++;
        $display("FAIL cfg_run cyc=%0d got=%h exp=%h",
                 cyc_n, obs, exp_v());
      end
    end
    n_chk++;
    if (cur_half !== 32'd0 || cfg_ready !== 1'b1 ||
        clk_out !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_bound half=%0d rdy=%b clk=%b exp 0/1/0",
               cur_half, cfg_ready, clk_out);
    end
    prev = clk_out;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, '0);
      n_chk++;
      if (clk_out !== ~prev || obs !== exp_v()) begin
        n_fail++;
        $display("FAIL div2 cyc=%0d got=%h exp=%h",
                 cyc_n, obs, exp_v());
      end
      prev = clk_out;
    end
  endtask

  task automatic test_stop_high();
    bit idle_seen;
    idle_seen = 0;
    set_half(3);
    cyc(1, 0, '0);
    for (int i = 0; i < 20 && m_pos != 6; i++) cyc(1, 0, '0);
    cyc(0, 0, '0);
    n_chk++;
    if (running !== 1'b1 || clk_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_enter run=%b clk=%b exp 1/1",
               running, clk_out);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, '0);
      if (!running) idle_seen = 1;
      n_chk++;
      if (obs !== exp_v()) begin
        n_fail++;
        $display("FAIL stop_high cyc=%0d got=%h exp=%h",
                 cyc_n, obs, exp_v());
      end
    end
    n_chk++;
    if (!idle_seen) begin
      n_fail++;
      $display("FAIL stop_idle running never 0, exp 0 once");
    end
  endtask

  task automatic test_stop_low();
    for (int i = 0; i < 20 && m_pos != 1; i++) cyc(1, 0, '0);
    cyc(0, 0, '0);
    n_chk++;
    if (running !== 1'b0 || clk_out !== 1'b0 ||
        tick !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_low run=%b clk=%b tick=%b exp 0/0/0",
               running, clk_out, tick);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0);
      n_chk++;
      if (obs !== exp_v()) begin
        n_fail++;
        $display("FAIL stop_low_hold got=%h exp=%h",
                 obs, exp_v());
      end
    end
  endtask

  task automatic test_max_half();
    set_half('1);
    n_chk++;
    if (cur_half !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL max_half got=%h exp=ffffffff", cur_half);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, '0);
      n_chk++;
      if (obs !== exp_v() || clk_out !== 1'b0) begin
        n_fail++;
        $display("FAIL max_run got=%h exp=%h", obs, exp_v());
      end
    end
    set_half(2);
    n_chk++;
    if (cur_half !== 32'd2) begin
      n_fail++;
      $display("FAIL max_back got=%0d exp=2", cur_half);
    end
  endtask

  task automatic test_random();
    bit e, v;
    logic [W-1:0] h;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(7) != 0);
      v = ($urandom_range(3) == 0);
      h = W'($urandom_range(6));
      cyc(e, v, h);
      n_chk++;
      if (obs !== exp_v()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 cyc_n, obs, exp_v());
      end
    end
  endtask

  task automatic test_async_reset();
    set_half(3);
    cyc(1, 0, '0);
    for (int i = 0; i < 20 && m_pos != 4; i++) cyc(1, 0, '0);
    cyc(1, 1, 4);
    n_chk++;
    if (clk_out !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_setup clk=%b rdy=%b exp 1/0",
               clk_out, cfg_ready);
    end
    cfg_valid = 0;
    #3 rst = 1;
    #1;
    n_chk++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL arst got=%h exp=%h", obs, RST_V);
    end
    m_reset();
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0);
      n_chk++;
      if (obs !== exp_v()) begin
        n_fail++;
        $display("FAIL arst_after got=%h exp=%h",
                 obs, exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_cfg_idle();
    test_cfg_run();
    test_stop_high();
    test_stop_low();
    test_max_half();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
